// File: rtl/mult_result_sat.sv
// ---------------------------------------------------------------------------
// mult_result_sat
//
// Downstream stage of the sequential `mult` multiplier. The block follows the
// multiplier's start/busy handshake and captures `prod` when a run finishes.
// It then scales the product by 2^-SHIFT and saturates it to a signed
// OUT_BITS value. Results wait in a 2-entry FIFO that the consumer drains
// through a valid/ready handshake.
//
// Optional build macro:
//   MULT_RESULT_ROUND_EN - when defined, the block adds 2^(SHIFT-1) before
//                          the arithmetic shift, which rounds half toward
//                          +inf. When undefined, the shift truncates toward
//                          -inf (floor). The FSM, the FIFO and the handshake
//                          are the same in both builds.
//
// Ports:
//   clk        in   rising-edge clock shared with mult
//   reset      in   asynchronous active-high reset
//   start      in   start pulse that also drives mult
//   busy       in   mult busy output
//   prod       in   [M_BITS+N_BITS-1:0] two's-complement product
//   out_data   out  [OUT_BITS-1:0] head-of-FIFO result, signed, registered
//   out_ovf    out  head-of-FIFO saturation flag, registered
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer accepts the head when out_valid is high
//   out_level  out  [1:0] FIFO occupancy, 0..2
//   err_lost   out  sticky; set when a run was ignored because staging was
//                   still occupied
// ---------------------------------------------------------------------------
module mult_result_sat #(
    parameter int M_BITS   = 12,
    parameter int N_BITS   = 8,
    parameter int SHIFT    = 4,
    parameter int OUT_BITS = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       busy,
    input  logic [M_BITS+N_BITS-1:0]   prod,
    output logic [OUT_BITS-1:0]        out_data,
    output logic                       out_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_level,
    output logic                       err_lost
);

    localparam int P_BITS = M_BITS + N_BITS;
    // One guard bit means the rounding bias can never wrap the sum.
    localparam int W_BITS = P_BITS + 1;
    // Each entry is stored as {ovf, data}.
    localparam int E_BITS = OUT_BITS + 1;

    localparam logic signed [W_BITS-1:0] C_SAT_MAX =
        {{(W_BITS-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [W_BITS-1:0] C_SAT_MIN =
        {{(W_BITS-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
    localparam logic [OUT_BITS-1:0] C_OUT_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic [OUT_BITS-1:0] C_OUT_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

`ifdef MULT_RESULT_ROUND_EN
    localparam logic signed [W_BITS-1:0] C_ROUND_BIAS =
        {{(W_BITS-1){1'b0}}, 1'b1} << (SHIFT - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_PUSH  = 2'd3
    } state_t;

    // Scale the product, saturate it, and return {ovf, data}.
    function automatic logic [E_BITS-1:0] f_scale_sat(input logic [P_BITS-1:0] p);
        logic signed [W_BITS-1:0] v_ext;
        logic signed [W_BITS-1:0] v_s;
        logic [E_BITS-1:0]        v_res;
        v_ext = $signed({p[P_BITS-1], p});
`ifdef MULT_RESULT_ROUND_EN
        v_ext = v_ext + C_ROUND_BIAS;
`endif
        v_s = v_ext >>> SHIFT;
        if (v_s > C_SAT_MAX) begin
            v_res = {1'b1, C_OUT_MAX};
        end else if (v_s < C_SAT_MIN) begin
            v_res = {1'b1, C_OUT_MIN};
        end else begin
            v_res = {1'b0, v_s[OUT_BITS-1:0]};
        end
        return v_res;
    endfunction

    state_t              r_state;
    logic [E_BITS-1:0]   r_stage;
    logic                r_err_lost;
    logic [E_BITS-1:0]   r_head;
    logic [E_BITS-1:0]   r_tail;
    logic [1:0]          r_level;
    logic                r_valid;

    logic [E_BITS-1:0]   w_res;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_level_nxt;

    // Compute the scaled, saturated result from the current product.
    always_comb begin
        w_res = f_scale_sat(prod);
    end

    // Derive the push and pop strobes from the registered FIFO level.
    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        if ((r_state == S_PUSH) && (r_level != 2'd2)) begin
            w_push = 1'b1;
        end else begin
            w_push = 1'b0;
        end
        if (r_valid && out_ready) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
    end

    // Compute the next FIFO occupancy. When push and pop happen together, the level stays the same.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + 2'd1;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - 2'd1;
        end else begin
            w_level_nxt = r_level;
        end
    end

    // Capture FSM. It follows start/busy, stages the result and sets the sticky lost-run flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_stage    <= {E_BITS{1'b0}};
            r_err_lost <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ARMED;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (busy) begin
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_ARMED;
                    end
                end
                S_RUN: begin
                    // A start pulse in mid-run means mult restarted, so the old run is discarded.
                    if (start) begin
                        r_state <= S_ARMED;
                    end else if (!busy) begin
                        r_stage <= w_res;
                        r_state <= S_PUSH;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_PUSH: begin
                    if (w_push) begin
                        if (start) begin
                            r_state <= S_ARMED;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        // A new run cannot be tracked while staging is full. Record that it was lost.
                        if (start) begin
                            r_err_lost <= 1'b1;
                        end else begin
                            r_err_lost <= r_err_lost;
                        end
                        r_state <= S_PUSH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-entry FIFO. The head register drives the outputs directly and keeps its value once the FIFO is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= {E_BITS{1'b0}};
            r_tail  <= {E_BITS{1'b0}};
            r_level <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != 2'd0);
            if (w_push && w_pop) begin
                // Only reachable at level 1: the new entry replaces the popped head.
                r_head <= r_stage;
            end else if (w_pop) begin
                if (r_level == 2'd2) begin
                    r_head <= r_tail;
                end else begin
                    r_head <= r_head;
                end
            end else if (w_push) begin
                if (r_level == 2'd0) begin
                    r_head <= r_stage;
                end else begin
                    r_tail <= r_stage;
                end
            end else begin
                r_head <= r_head;
                r_tail <= r_tail;
            end
        end
    end

    assign out_data  = r_head[OUT_BITS-1:0];
    assign out_ovf   = r_head[OUT_BITS];
    assign out_valid = r_valid;
    assign out_level = r_level;
    assign err_lost  = r_err_lost;

endmodule

// File: tb/tb_mult_result_sat.sv
module tb_mult_result_sat;

    localparam int M_BITS   = 12;
    localparam int N_BITS   = 8;
    localparam int SHIFT    = 4;
    localparam int OUT_BITS = 12;
    localparam int P_BITS   = M_BITS + N_BITS;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic                 busy;
    logic [P_BITS-1:0]    prod;
    logic [OUT_BITS-1:0]  out_data;
    logic                 out_ovf;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_level;
    logic                 err_lost;

    int n_tests;
    int n_fail;
    logic [OUT_BITS:0] sb_q[$];
    logic [OUT_BITS:0] last_popped;

    mult_result_sat #(
        .M_BITS(M_BITS), .N_BITS(N_BITS), .SHIFT(SHIFT), .OUT_BITS(OUT_BITS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .prod(prod),
        .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid),
        .out_ready(out_ready), .out_level(out_level), .err_lost(err_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: floor division on integers, optional +half bias, saturation.
    function automatic logic [OUT_BITS:0] model(input logic [P_BITS-1:0] p);
        longint v;
        longint d;
        longint q;
        longint maxv;
        longint minv;
        v = longint'($signed(p));
        d = 64'sd1 <<< SHIFT;
`ifdef MULT_RESULT_ROUND_EN
        v = v + d / 2;
`endif
        q = v / d;
        if (((v % d) != 0) && (v < 0)) q = q - 1;
        maxv = (64'sd1 <<< (OUT_BITS - 1)) - 1;
        minv = -(64'sd1 <<< (OUT_BITS - 1));
        if (q > maxv)      return {1'b1, 1'b0, {(OUT_BITS-1){1'b1}}};
        else if (q < minv) return {1'b1, 1'b1, {(OUT_BITS-1){1'b0}}};
        else               return {1'b0, q[OUT_BITS-1:0]};
    endfunction

    // Drive one mult run. Returns at the negedge after the capture edge.
    task automatic do_run(input logic [P_BITS-1:0] p, input bit exp_push);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0; busy = 1'b1;
        repeat (2) @(negedge clk);
        prod = p; busy = 1'b0;
        if (exp_push) sb_q.push_back(model(p));
        @(negedge clk);
    endtask

    // Scoreboard consumer: wait for the head, compare it, then pop it with a single ready pulse.
    task automatic drain(input int n, input string tag);
        logic [OUT_BITS:0] exp;
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            n_tests++;
            if (!out_valid) begin
                n_fail++;
                $display("FAIL %s_timeout[%0d]: out_valid=%b required 1", tag, i, out_valid);
            end else if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_extra[%0d]: got %h required no entry", tag, i, out_data);
                out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
            end else begin
                exp = sb_q.pop_front();
                last_popped = exp;
                if ({out_ovf, out_data} !== exp) begin
                    n_fail++;
                    $display("FAIL %s_data[%0d]: got ovf=%b data=%h required ovf=%b data=%h",
                             tag, i, out_ovf, out_data, exp[OUT_BITS], exp[OUT_BITS-1:0]);
                end
                out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({out_valid, out_level, out_data, out_ovf, err_lost} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset: got valid=%b level=%0d data=%h ovf=%b lost=%b required all 0",
                     out_valid, out_level, out_data, out_ovf, err_lost);
        end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_in_range();
        do_run(20'd16384, 1'b1);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_early: out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_level !== 2'd1) begin
            n_fail++; $display("FAIL latency_valid: valid=%b level=%0d required 1/1", out_valid, out_level);
        end
        n_tests++;
        if (out_data !== 12'h400 || out_ovf !== 1'b0) begin
            n_fail++; $display("FAIL in_range: got %h ovf=%b required 400 ovf=0", out_data, out_ovf);
        end
        drain(1, "in_range");
    endtask

    task automatic test_neg_sat();
        do_run(20'(-98240), 1'b1);
        @(negedge clk);
        n_tests++;
        if (out_data !== 12'h800 || out_ovf !== 1'b1) begin
            n_fail++; $display("FAIL neg_sat: got %h ovf=%b required 800 ovf=1", out_data, out_ovf);
        end
        drain(1, "neg_sat");
    endtask

    task automatic test_rounding();
        do_run(20'd24, 1'b1);
        do_run(20'(-24), 1'b1);
        do_run(20'h7FFFF, 1'b1);
        drain(3, "round");
    endtask

    task automatic test_empty_pop();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (out_level !== 2'd0 || out_valid !== 1'b0 || {out_ovf, out_data} !== last_popped) begin
            n_fail++;
            $display("FAIL empty_pop: level=%0d valid=%b data=%h required 0/0/%h",
                     out_level, out_valid, out_data, last_popped[OUT_BITS-1:0]);
        end
    endtask

    task automatic test_push_pop_same();
        logic [OUT_BITS:0] exp;
        do_run(20'd800, 1'b1);
        @(negedge clk);
        do_run(20'(-1000), 1'b1);
        exp = sb_q.pop_front();
        n_tests++;
        if ({out_ovf, out_data} !== exp || out_level !== 2'd1) begin
            n_fail++; $display("FAIL pp_head: got %h level=%0d required %h level 1", out_data, out_level, exp[OUT_BITS-1:0]);
        end
        out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
        n_tests++;
        if (out_level !== 2'd1 || {out_ovf, out_data} !== sb_q[0]) begin
            n_fail++; $display("FAIL pp_same: got %h level=%0d required %h level 1", out_data, out_level, sb_q[0][OUT_BITS-1:0]);
        end
        drain(1, "pp");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_run(20'd1600, 1'b1);
        do_run(20'(-3200), 1'b1);
        do_run(20'd4800, 1'b1);
        @(negedge clk);
        n_tests++;
        if (out_level !== 2'd2 || err_lost !== 1'b0) begin
            n_fail++; $display("FAIL bp_full: level=%0d lost=%b required 2/0", out_level, err_lost);
        end
        do_run(20'd333, 1'b0);
        n_tests++;
        if (err_lost !== 1'b1 || out_level !== 2'd2) begin
            n_fail++; $display("FAIL bp_lost: lost=%b level=%0d required 1/2", err_lost, out_level);
        end
        drain(3, "bp");
        repeat (4) @(negedge clk);
        n_tests++;
        if (out_level !== 2'd0 || out_valid !== 1'b0 || err_lost !== 1'b1) begin
            n_fail++; $display("FAIL bp_end: level=%0d valid=%b lost=%b required 0/0/1", out_level, out_valid, err_lost);
        end
    endtask

    task automatic test_restart();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0; busy = 1'b1; prod = 20'd5000;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
        prod = 20'd2000; busy = 1'b0;
        sb_q.push_back(model(20'd2000));
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_level !== 2'd1) begin
            n_fail++; $display("FAIL restart_level: level=%0d required 1", out_level);
        end
        drain(1, "restart");
    endtask

    task automatic test_reset_mid_run();
        do_run(20'd1234, 1'b1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0; busy = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, out_level, out_data, out_ovf, err_lost} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b level=%0d data=%h ovf=%b lost=%b required all 0",
                     out_valid, out_level, out_data, out_ovf, err_lost);
        end
        sb_q.delete();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) prod = 20'd4000; busy = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || out_level !== 2'd0) begin
            n_fail++; $display("FAIL reset_after: valid=%b level=%0d required 0/0", out_valid, out_level);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        last_popped = '0;
        reset = 1'b1; start = 1'b0; busy = 1'b0; prod = '0; out_ready = 1'b0;
        test_reset();
        test_in_range();
        test_neg_sat();
        test_rounding();
        test_empty_pop();
        test_push_pop_same();
        test_backpressure();
        test_restart();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
